// File: rtl/count_arbiter.sv
// Round-robin arbiter that shares one tick-paced LED counting engine among
// NUM_REQ requesters; each completed run ends with a one-cycle done pulse.
module count_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 1500000,
    parameter int CNT_W     = 4,
    parameter int COUNT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [CNT_W-1:0]   led,
    output logic               busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: req is a level held by a requester until its done pulse;
    // grant is one-hot while that requester owns the engine; dropping req
    // during the run aborts it with no done pulse.
    state_t             state, state_n;
    logic [TW-1:0]      tick_cnt, tick_cnt_n;
    logic               tick;
    logic [IW-1:0]      owner, owner_n;
    logic [IW-1:0]      last_grant, last_grant_n;
    logic [IW-1:0]      sel;
    logic               sel_valid;
    logic [NUM_REQ-1:0] grant_n, done_n;
    logic [CNT_W-1:0]   led_n;

    function automatic logic [IW-1:0] wrap_idx(input int v);
        return IW'(v % NUM_REQ);
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IW-1:0] i);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

    // First asserted requester strictly after last_grant, wrapping around.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!sel_valid && req[wrap_idx(int'(last_grant) + i)]) begin
                sel       = wrap_idx(int'(last_grant) + i);
                sel_valid = 1'b1;
            end
        end
    end

    assign tick = (state == RUN) && (tick_cnt == TW'(TICK_DIV - 1));
    assign busy = (state == RUN) || (state == DONE);

    always_comb begin
        state_n      = state;
        tick_cnt_n   = '0;
        owner_n      = owner;
        last_grant_n = last_grant;
        grant_n      = '0;
        done_n       = '0;
        led_n        = '0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_n = RUN;
                    owner_n = sel;
                    grant_n = one_hot(sel);
                end
            end
            RUN: begin
                grant_n = grant;
                led_n   = led;
                // Abort wins over a coincident tick.
                if (!req[owner]) begin
                    state_n      = IDLE;
                    grant_n      = '0;
                    led_n        = '0;
                    last_grant_n = owner;
                end else if (tick) begin
                    if (led == CNT_W'(COUNT_MAX)) begin
                        state_n = DONE;
                        grant_n = '0;
                        led_n   = '0;
                        done_n  = one_hot(owner);
                    end else begin
                        led_n = led + CNT_W'(1);
                    end
                end else begin
                    tick_cnt_n = tick_cnt + TW'(1);
                end
            end
            DONE: begin
                state_n      = IDLE;
                last_grant_n = owner;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            owner      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            grant      <= '0;
            done       <= '0;
            led        <= '0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_cnt_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            done       <= done_n;
            led        <= led_n;
        end
    end

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: directed scenarios plus random requests, checked
// every cycle against a run-timing model and against fixed expected values.
module tb_count_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int CW = 4;
    localparam int CM = 3;
    localparam int RUN_LEN = (CM + 1) * TD;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [CW-1:0] led;
    logic          busy;

    count_arbiter #(
        .NUM_REQ  (N),
        .TICK_DIV (TD),
        .CNT_W    (CW),
        .COUNT_MAX(CM)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .grant(grant),
        .done (done),
        .led  (led),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: owner, clocks elapsed since its grant edge, and pending done cycle.
    bit            m_run;
    bit            m_fin;
    int            m_owner;
    int            m_fin_owner;
    int            m_elapsed;
    int            m_last;
    logic [N-1:0]  exp_grant;
    logic [N-1:0]  exp_done;
    logic [CW-1:0] exp_led;
    logic          exp_busy;

    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  got_q[$];
    int            done_cnt[N];

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    task automatic model_outputs();
        logic [N-1:0] one;
        one       = 1;
        exp_grant = m_run ? (one << m_owner) : '0;
        exp_done  = m_fin ? (one << m_fin_owner) : '0;
        exp_led   = m_run ? CW'(m_elapsed / TD) : '0;
        exp_busy  = m_run || m_fin;
    endtask

    task automatic model_reset();
        m_run       = 0;
        m_fin       = 0;
        m_owner     = 0;
        m_fin_owner = 0;
        m_elapsed   = 0;
        m_last      = N - 1;
        model_outputs();
    endtask

    task automatic model_edge();
        if (m_run) begin
            if (!req[m_owner]) begin
                m_run  = 0;
                m_last = m_owner;
            end else begin
                m_elapsed++;
                if (m_elapsed == RUN_LEN) begin
                    m_run       = 0;
                    m_fin       = 1;
                    m_fin_owner = m_owner;
                end
            end
        end else if (m_fin) begin
            m_fin  = 0;
            m_last = m_fin_owner;
        end else if (req != '0) begin
            m_owner   = rr_pick(req, m_last);
            m_run     = 1;
            m_elapsed = 0;
        end
        model_outputs();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        chk({tag, "_done"},  32'(done),  32'(exp_done));
        chk({tag, "_led"},   32'(led),   32'(exp_led));
        chk({tag, "_busy"},  32'(busy),  32'(exp_busy));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // Run n cycles; optionally each requester drops req on its own done.
    task automatic run(input int n, input bit drop, input string tag);
        logic [N-1:0] prev;
        prev = grant;
        for (int k = 0; k < n; k++) begin
            cycle(tag);
            if (prev == '0 && grant != '0) got_q.push_back(grant);
            for (int b = 0; b < N; b++) if (done[b] === 1'b1) done_cnt[b]++;
            prev = grant;
            if (drop) req = req & ~exp_done;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_log();
        got_q.delete();
        exp_q.delete();
        for (int b = 0; b < N; b++) done_cnt[b] = 0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        model_reset();
        #1;
        check_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: single run
        req = 4'b0001;
        cycle("t1");
        chk("t1_grant_latency", 32'(grant), 32'h1);
        repeat (RUN_LEN - 1) cycle("t1");
        chk("t1_no_early_done", 32'(done), 32'h0);
        cycle("t1");
        chk("t1_done_at_16", 32'(done), 32'h1);
        req = '0;
        cycle("t1_after");
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // 2: round-robin from reset with all requesting
        do_reset();
        clear_log();
        req = 4'b1111;
        run(4 * (RUN_LEN + 2) + 2, 1'b1, "t2");
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        chk("t2_grant_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk("t2_grant_order", 32'(got_q[k]), 32'(exp_q[k]));
        for (int b = 0; b < N; b++) chk("t2_done_count", 32'(done_cnt[b]), 32'h1);

        // 3: fairness wrap after requester 2 finishes
        req = 4'b0100;
        run(RUN_LEN + 2, 1'b1, "t3a");
        clear_log();
        req = 4'b0101;
        run(2 * (RUN_LEN + 2) + 4, 1'b1, "t3");
        exp_q = '{4'b0001, 4'b0100};
        chk("t3_grant_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk("t3_grant_order", 32'(got_q[k]), 32'(exp_q[k]));

        // 4: abort at led=2
        req = 4'b0010;
        cycle("t4");
        chk("t4_grant", 32'(grant), 32'h2);
        repeat (2 * TD) cycle("t4");
        chk("t4_led_before_abort", 32'(led), 32'h2);
        req = '0;
        cycle("t4_abort");
        chk("t4_abort_grant", 32'(grant), 32'h0);
        chk("t4_abort_led", 32'(led), 32'h0);
        chk("t4_abort_done", 32'(done), 32'h0);
        repeat (3) cycle("t4_idle");
        req = 4'b0011;
        cycle("t4_regrant");
        chk("t4_regrant", 32'(grant), 32'h1);
        req = 4'b0001;
        run(RUN_LEN + 2, 1'b1, "t4_fin");

        // 5: asynchronous reset mid-run
        req = 4'b1000;
        cycle("t5");
        repeat (2 * TD) cycle("t5");
        chk("t5_led_before_rst", 32'(led), 32'h2);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("t5_async_rst");
        @(negedge clk);
        rst = 1'b0;
        cycle("t5_post");
        chk("t5_post_grant", 32'(grant), 32'h8);
        run(RUN_LEN + 1, 1'b1, "t5_fin");
        req = 4'b1001;
        cycle("t5_next");
        chk("t5_next_grant", 32'(grant), 32'h1);
        req = 4'b0001;
        run(RUN_LEN + 1, 1'b1, "t5_fin2");

        // 6: non-owner request during a run
        req = 4'b0001;
        cycle("t6");
        chk("t6_grant", 32'(grant), 32'h1);
        repeat (5) cycle("t6");
        req = 4'b0101;
        repeat (3) cycle("t6_pulse");
        req = 4'b0001;
        repeat (RUN_LEN - 9) cycle("t6");
        chk("t6_led_last", 32'(led), 32'(CM));
        cycle("t6_done");
        chk("t6_done", 32'(done), 32'h1);
        req = '0;
        run(3, 1'b0, "t6_idle");

        // 7: random requests, including aborts and re-competition
        for (int k = 0; k < 600; k++) begin
            cycle("rand");
            req = req & ~exp_done;
            if ($urandom_range(0, 3) == 0) begin
                int b;
                b = $urandom_range(0, N - 1);
                req[b] = ~req[b];
            end
            if ($urandom_range(0, 63) == 0) req = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
